// File: rtl/idex_latch.sv
// ID/EX pipeline register: captures decode-stage fields for execute and the hazard unit.
// Supports hold (en=0), load-use bubble, and jump/branch squash, with saturating event counters.
module idex_latch #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              lw_nop,
  input  logic              jmp_flush,
  input  logic              brch_flush,
  input  logic              valid_in,
  input  logic [WORD_W-1:0] pcplus4_in,
  input  logic [WORD_W-1:0] rdat1_in,
  input  logic [WORD_W-1:0] rdat2_in,
  input  logic [WORD_W-1:0] imm_in,
  input  logic [REG_W-1:0]  rs_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [3:0]        aluop_in,
  input  logic              alusrc_in,
  input  logic              dren_in,
  input  logic              dwen_in,
  input  logic              regwen_in,
  input  logic              memtoreg_in,
  input  logic              halt_in,
  input  logic [1:0]        pcsrc_in,
  output logic              valid_out,
  output logic [WORD_W-1:0] pcplus4_out,
  output logic [WORD_W-1:0] rdat1_out,
  output logic [WORD_W-1:0] rdat2_out,
  output logic [WORD_W-1:0] imm_out,
  output logic [REG_W-1:0]  rs_out,
  output logic [REG_W-1:0]  rt_out,
  output logic [REG_W-1:0]  rd_out,
  output logic [3:0]        aluop_out,
  output logic              alusrc_out,
  output logic              dren_out,
  output logic              dwen_out,
  output logic              regwen_out,
  output logic              memtoreg_out,
  output logic              halt_out,
  output logic [1:0]        pcsrc_out,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // All-zero value of this struct is the NOP slot.
  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] pcplus4;
    logic [WORD_W-1:0] rdat1;
    logic [WORD_W-1:0] rdat2;
    logic [WORD_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [3:0]        aluop;
    logic              alusrc;
    logic              dren;
    logic              dwen;
    logic              regwen;
    logic              memtoreg;
    logic              halt;
    logic [1:0]        pcsrc;
  } idex_t;

  // State names the action taken on the most recent edge.
  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StHold   = 2'b01,
    StBubble = 2'b10,
    StSquash = 2'b11
  } state_e;

  idex_t            in_pkt;
  idex_t            idex_d, idex_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  state_e           state_d, state_q;
  logic             flush;

  assign flush = jmp_flush | brch_flush;

  assign in_pkt = '{
    valid:    valid_in,
    pcplus4:  pcplus4_in,
    rdat1:    rdat1_in,
    rdat2:    rdat2_in,
    imm:      imm_in,
    rs:       rs_in,
    rt:       rt_in,
    rd:       rd_in,
    aluop:    aluop_in,
    alusrc:   alusrc_in,
    dren:     dren_in,
    dwen:     dwen_in,
    regwen:   regwen_in,
    memtoreg: memtoreg_in,
    halt:     halt_in,
    pcsrc:    pcsrc_in
  };

  // Next-state: hold beats flush beats bubble beats normal load.
  always_comb begin
    idex_d       = idex_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    state_d      = StHold;
    if (en) begin
      if (flush) begin
        // Clearing pcsrc here stops the hazard unit from re-flushing next cycle.
        idex_d  = '0;
        state_d = StSquash;
        if (flush_cnt_q != {CNT_W{1'b1}}) begin
          flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
      end else if (lw_nop) begin
        // Clearing dren here limits a load-use stall to one cycle.
        idex_d  = '0;
        state_d = StBubble;
        if (bubble_cnt_q != {CNT_W{1'b1}}) begin
          bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
      end else begin
        idex_d  = in_pkt;
        state_d = StRun;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      idex_q       <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
      state_q      <= StRun;
    end else begin
      idex_q       <= idex_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      state_q      <= state_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    valid_out    = idex_q.valid;
    pcplus4_out  = idex_q.pcplus4;
    rdat1_out    = idex_q.rdat1;
    rdat2_out    = idex_q.rdat2;
    imm_out      = idex_q.imm;
    rs_out       = idex_q.rs;
    rt_out       = idex_q.rt;
    rd_out       = idex_q.rd;
    aluop_out    = idex_q.aluop;
    alusrc_out   = idex_q.alusrc;
    dren_out     = idex_q.dren;
    dwen_out     = idex_q.dwen;
    regwen_out   = idex_q.regwen;
    memtoreg_out = idex_q.memtoreg;
    halt_out     = idex_q.halt;
    pcsrc_out    = idex_q.pcsrc;
    bubble_cnt   = bubble_cnt_q;
    flush_cnt    = flush_cnt_q;
  end

endmodule

// File: tb/tb_idex_latch.sv
// Bench for idex_latch: directed table, hand sequences, randomized run against a reference model.
module tb_idex_latch;

  typedef struct packed {
    logic        valid;
    logic [31:0] pcplus4;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  aluop;
    logic        alusrc;
    logic        dren;
    logic        dwen;
    logic        regwen;
    logic        memtoreg;
    logic        halt;
    logic [1:0]  pcsrc;
  } fields_t;

  typedef struct {
    bit          en, lw, jf, bf;
    logic [1:0]  pcsrc;
    logic [31:0] rdat1;
    logic [4:0]  rt;
    logic        dren, valid;
    logic [1:0]  e_pcsrc;
    logic [31:0] e_rdat1;
    logic [4:0]  e_rt;
    logic        e_dren, e_valid;
    int          e_b, e_f;
  } vec_t;

  logic    CLK = 1'b0;
  logic    nRST = 1'b0;
  logic    en = 1'b0, lw_nop = 1'b0, jmp_flush = 1'b0, brch_flush = 1'b0;
  fields_t in_f = '0;
  fields_t out_f;
  logic        valid_out, alusrc_out, dren_out, dwen_out, regwen_out, memtoreg_out, halt_out;
  logic [31:0] pcplus4_out, rdat1_out, rdat2_out, imm_out;
  logic [4:0]  rs_out, rt_out, rd_out;
  logic [3:0]  aluop_out;
  logic [1:0]  pcsrc_out;
  logic [15:0] bubble_cnt, flush_cnt;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  idex_latch dut (
    .CLK(CLK), .nRST(nRST), .en(en), .lw_nop(lw_nop), .jmp_flush(jmp_flush),
    .brch_flush(brch_flush), .valid_in(in_f.valid), .pcplus4_in(in_f.pcplus4),
    .rdat1_in(in_f.rdat1), .rdat2_in(in_f.rdat2), .imm_in(in_f.imm), .rs_in(in_f.rs),
    .rt_in(in_f.rt), .rd_in(in_f.rd), .aluop_in(in_f.aluop), .alusrc_in(in_f.alusrc),
    .dren_in(in_f.dren), .dwen_in(in_f.dwen), .regwen_in(in_f.regwen),
    .memtoreg_in(in_f.memtoreg), .halt_in(in_f.halt), .pcsrc_in(in_f.pcsrc),
    .valid_out(valid_out), .pcplus4_out(pcplus4_out), .rdat1_out(rdat1_out),
    .rdat2_out(rdat2_out), .imm_out(imm_out), .rs_out(rs_out), .rt_out(rt_out),
    .rd_out(rd_out), .aluop_out(aluop_out), .alusrc_out(alusrc_out), .dren_out(dren_out),
    .dwen_out(dwen_out), .regwen_out(regwen_out), .memtoreg_out(memtoreg_out),
    .halt_out(halt_out), .pcsrc_out(pcsrc_out), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
  );

  assign out_f = {valid_out, pcplus4_out, rdat1_out, rdat2_out, imm_out, rs_out, rt_out,
                  rd_out, aluop_out, alusrc_out, dren_out, dwen_out, regwen_out,
                  memtoreg_out, halt_out, pcsrc_out};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  vec_t    tbl[12];
  fields_t m_f;
  int      m_b, m_f_cnt;
  fields_t e;

  initial begin
    // Reset check
    step();
    step();
    chk("reset_fields", 256'(out_f), 256'(0));
    chk("reset_cnts", {bubble_cnt, flush_cnt}, 0);
    nRST = 1'b1;

    tbl[0]  = '{1,0,0,0, 2'b00, 32'hDEADBEEF, 5'd5, 1, 1, 2'b00, 32'hDEADBEEF, 5'd5, 1, 1, 0, 0};
    tbl[1]  = '{1,1,0,0, 2'b10, 32'h11111111, 5'd3, 1, 1, 2'b00, 32'h0, 5'd0, 0, 0, 1, 0};
    tbl[2]  = '{1,0,0,0, 2'b11, 32'h22222222, 5'd7, 0, 1, 2'b11, 32'h22222222, 5'd7, 0, 1, 1, 0};
    tbl[3]  = '{1,0,1,0, 2'b01, 32'h33333333, 5'd1, 1, 1, 2'b00, 32'h0, 5'd0, 0, 0, 1, 1};
    tbl[4]  = '{1,1,0,1, 2'b10, 32'h3A3A3A3A, 5'd2, 1, 1, 2'b00, 32'h0, 5'd0, 0, 0, 1, 2};
    tbl[5]  = '{0,0,1,0, 2'b11, 32'h44444444, 5'd4, 1, 1, 2'b00, 32'h0, 5'd0, 0, 0, 1, 2};
    tbl[6]  = '{0,1,0,0, 2'b11, 32'h4B4B4B4B, 5'd6, 1, 1, 2'b00, 32'h0, 5'd0, 0, 0, 1, 2};
    tbl[7]  = '{1,0,0,0, 2'b01, 32'h55555555, 5'd9, 1, 1, 2'b01, 32'h55555555, 5'd9, 1, 1, 1, 2};
    tbl[8]  = '{0,0,1,0, 2'b11, 32'h66666666, 5'd8, 0, 0, 2'b01, 32'h55555555, 5'd9, 1, 1, 1, 2};
    tbl[9]  = '{0,0,0,1, 2'b10, 32'h67676767, 5'd10, 0, 0, 2'b01, 32'h55555555, 5'd9, 1, 1, 1, 2};
    tbl[10] = '{0,1,0,0, 2'b00, 32'h68686868, 5'd11, 0, 0, 2'b01, 32'h55555555, 5'd9, 1, 1, 1, 2};
    tbl[11] = '{1,0,0,0, 2'b10, 32'h77777777, 5'd2, 0, 1, 2'b10, 32'h77777777, 5'd2, 0, 1, 1, 2};

    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en; lw_nop = tbl[i].lw; jmp_flush = tbl[i].jf; brch_flush = tbl[i].bf;
      in_f = '0;
      in_f.pcsrc = tbl[i].pcsrc; in_f.rdat1 = tbl[i].rdat1; in_f.rt = tbl[i].rt;
      in_f.dren = tbl[i].dren; in_f.valid = tbl[i].valid; in_f.halt = tbl[i].valid;
      step();
      e = '0;
      e.pcsrc = tbl[i].e_pcsrc; e.rdat1 = tbl[i].e_rdat1; e.rt = tbl[i].e_rt;
      e.dren = tbl[i].e_dren; e.valid = tbl[i].e_valid; e.halt = tbl[i].e_valid;
      chk($sformatf("tbl%0d_fields", i), 256'(out_f), 256'(e));
      chk($sformatf("tbl%0d_bubble", i), 256'(bubble_cnt), 256'(tbl[i].e_b));
      chk($sformatf("tbl%0d_flush", i), 256'(flush_cnt), 256'(tbl[i].e_f));
    end

    // Randomized run; model state carried from the table's final point
    m_f = e; m_b = 1; m_f_cnt = 2;
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      lw_nop = ($urandom_range(0, 4) == 0);
      jmp_flush = ($urandom_range(0, 9) == 0);
      brch_flush = ($urandom_range(0, 9) == 0);
      in_f = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step();
      if (en) begin
        if (jmp_flush || brch_flush) begin
          m_f = '0;
          m_f_cnt = (m_f_cnt < 65535) ? m_f_cnt + 1 : 65535;
        end else if (lw_nop) begin
          m_f = '0;
          m_b = (m_b < 65535) ? m_b + 1 : 65535;
        end else begin
          m_f = in_f;
        end
      end
      chk($sformatf("rnd%0d_fields", i), 256'(out_f), 256'(m_f));
      chk($sformatf("rnd%0d_cnts", i), {bubble_cnt, flush_cnt}, {m_b[15:0], m_f_cnt[15:0]});
    end

    // Asynchronous reset mid-cycle with every input nonzero
    en = 1'b1; lw_nop = 1'b1; jmp_flush = 1'b1; brch_flush = 1'b1; in_f = '1;
    chk("pre_reset_cnts_nonzero", 256'({bubble_cnt, flush_cnt} != 0), 256'(1));
    #2;
    nRST = 1'b0;
    #1;
    chk("async_reset_fields", 256'(out_f), 256'(0));
    chk("async_reset_cnts", {bubble_cnt, flush_cnt}, 0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("post_release_fields", 256'(out_f), 256'(0));

    // Bubble counter saturation
    in_f = '0; en = 1'b1; lw_nop = 1'b1; jmp_flush = 1'b0; brch_flush = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 1; i < 65534; i++) step();
    chk("sat_fffe", 256'(bubble_cnt), 256'(16'hFFFE));
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sat_ffff_%0d", i), 256'(bubble_cnt), 256'(16'hFFFF));
    end
    chk("sat_flush_untouched", 256'(flush_cnt), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
